// File: rtl/alu_muldiv_pkg.sv
// alu_muldiv_pkg: shared Alu_Func encoding, mul/div FSM states and op classifiers.
// Madd/Maddu/Msub/Msubu codes exist only under ALU_MULDIV_MADD_EN.
package alu_muldiv_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_MULT  = 4'd4,
        ALU_MULTU = 4'd5,
        ALU_DIV   = 4'd6,
        ALU_DIVU  = 4'd7,
        ALU_MFHI  = 4'd8,
        ALU_MFLO  = 4'd9,
        ALU_MTHI  = 4'd10,
        ALU_MTLO  = 4'd11
`ifdef ALU_MULDIV_MADD_EN
        ,
        ALU_MADD  = 4'd12,
        ALU_MADDU = 4'd13,
        ALU_MSUB  = 4'd14,
        ALU_MSUBU = 4'd15
`endif
    } Alu_Func_T;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} md_state_t;

    typedef enum logic {MODE_MUL, MODE_DIV} md_mode_t;

    function automatic logic is_md_start(Alu_Func_T f);
`ifdef ALU_MULDIV_MADD_EN
        return f inside {ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU,
                         ALU_MADD, ALU_MADDU, ALU_MSUB, ALU_MSUBU};
`else
        return f inside {ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU};
`endif
    endfunction

    function automatic logic is_signed_op(Alu_Func_T f);
`ifdef ALU_MULDIV_MADD_EN
        return f inside {ALU_MULT, ALU_DIV, ALU_MADD, ALU_MSUB};
`else
        return f inside {ALU_MULT, ALU_DIV};
`endif
    endfunction

    function automatic logic is_hilo(Alu_Func_T f);
        return is_md_start(f) | (f inside {ALU_MFHI, ALU_MFLO, ALU_MTHI, ALU_MTLO});
    endfunction

endpackage

// File: rtl/alu_muldiv_if.sv
// alu_muldiv_if: issue/read bus between the execute stage (master) and the mul/div unit (slave).
interface alu_muldiv_if import alu_muldiv_pkg::*; #(
    parameter int DATA_W = 32
);
    logic              issue;
    Alu_Func_T         func;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
    logic [DATA_W-1:0] result;
    logic              zero;
    logic              busy;
    logic              stall;
    logic              done;

    modport master (output issue, func, data1, data2, input result, zero, busy, stall, done);
    modport slave  (input issue, func, data1, data2, output result, zero, busy, stall, done);
endinterface

// File: rtl/alu_muldiv_step.sv
// alu_muldiv_step: one iteration of shift-add multiply or restoring divide on {hi,lo} accumulator.
module alu_muldiv_step import alu_muldiv_pkg::*; #(
    parameter int DATA_W = 32
) (
    input  logic [2*DATA_W-1:0] acc_i,
    input  logic [DATA_W-1:0]   opnd_i,
    input  md_mode_t            mode_i,
    output logic [2*DATA_W-1:0] acc_o
);
    logic [DATA_W:0]   sum;
    logic [DATA_W+1:0] diff;
    logic [DATA_W-1:0] rem;

    // diff top bit is the borrow: set when the shifted remainder is below the divisor
    always_comb begin
        sum   = {1'b0, acc_i[2*DATA_W-1:DATA_W]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
        diff  = {1'b0, acc_i[2*DATA_W-1:DATA_W-1]} - {2'b0, opnd_i};
        rem   = diff[DATA_W+1] ? acc_i[2*DATA_W-2:DATA_W-1] : diff[DATA_W-1:0];
        acc_o = (mode_i == MODE_DIV) ? {rem, acc_i[DATA_W-2:0], ~diff[DATA_W+1]}
                                     : {sum, acc_i[DATA_W-1:1]};
    end
endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative signed/unsigned mul/div with HI/LO pair, move ops and pipeline stall.
// Optional Madd/Maddu/Msub/Msubu accumulate ops enabled by ALU_MULDIV_MADD_EN.
module alu_muldiv import alu_muldiv_pkg::*; #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W + 1)
) (
    input logic         clock,
    input logic         reset_n,
    alu_muldiv_if.slave mdu
);
    localparam int W2 = 2 * DATA_W;

    md_state_t         state_q;
    md_mode_t          mode_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] hi_q, lo_q, opnd_q;
    logic [W2-1:0]     acc_q, acc_d, prod_fix, fix_val;
    logic              neg_q, rneg_q, done_q;
    logic              busy, s1, s2;
    logic [DATA_W-1:0] a_abs, b_abs, quo, rem;
`ifdef ALU_MULDIV_MADD_EN
    logic              madd_q, msub_q;
    logic [W2-1:0]     base;
`endif

    assign busy  = state_q != S_IDLE;
    assign s1    = is_signed_op(mdu.func) & mdu.data1[DATA_W-1];
    assign s2    = is_signed_op(mdu.func) & mdu.data2[DATA_W-1];
    assign a_abs = s1 ? -mdu.data1 : mdu.data1;
    assign b_abs = s2 ? -mdu.data2 : mdu.data2;

    alu_muldiv_step #(.DATA_W(DATA_W)) u_step (
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .mode_i (mode_q),
        .acc_o  (acc_d)
    );

    // neg_q is cleared for a zero divisor so the all-ones quotient survives unsigned
    assign quo      = neg_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
    assign rem      = rneg_q ? -acc_q[W2-1:DATA_W] : acc_q[W2-1:DATA_W];
    assign prod_fix = neg_q ? -acc_q : acc_q;
`ifdef ALU_MULDIV_MADD_EN
    assign base    = (mode_q == MODE_DIV) ? {rem, quo} : prod_fix;
    assign fix_val = madd_q ? {hi_q, lo_q} + base : msub_q ? {hi_q, lo_q} - base : base;
`else
    assign fix_val = (mode_q == MODE_DIV) ? {rem, quo} : prod_fix;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            mode_q  <= MODE_MUL;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            opnd_q  <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef ALU_MULDIV_MADD_EN
            madd_q  <= 1'b0;
            msub_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: if (mdu.issue) begin
                    if (is_md_start(mdu.func)) begin
                        state_q <= S_RUN;
                        cnt_q   <= CNT_W'(DATA_W);
                        acc_q   <= {{DATA_W{1'b0}}, a_abs};
                        opnd_q  <= b_abs;
                        mode_q  <= (mdu.func inside {ALU_DIV, ALU_DIVU}) ? MODE_DIV : MODE_MUL;
                        neg_q   <= (s1 ^ s2) & (|mdu.data2);
                        rneg_q  <= s1;
`ifdef ALU_MULDIV_MADD_EN
                        madd_q  <= mdu.func inside {ALU_MADD, ALU_MADDU};
                        msub_q  <= mdu.func inside {ALU_MSUB, ALU_MSUBU};
`endif
                    end
                    if (mdu.func == ALU_MTHI) hi_q <= mdu.data1;
                    if (mdu.func == ALU_MTLO) lo_q <= mdu.data1;
                end
                S_RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) state_q <= S_FIX;
                end
                S_FIX: begin
                    {hi_q, lo_q} <= fix_val;
                    done_q       <= 1'b1;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mdu.busy   = busy;
    assign mdu.done   = done_q;
    assign mdu.stall  = mdu.issue & busy & is_hilo(mdu.func);
    assign mdu.result = (mdu.issue & ~busy) ? ((mdu.func == ALU_MFHI) ? hi_q :
                                               (mdu.func == ALU_MFLO) ? lo_q : '0) : '0;
    assign mdu.zero   = mdu.result == '0;
endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: scoreboard bench for alu_muldiv at DATA_W=4 (Madd checks under ALU_MULDIV_MADD_EN).
module tb_alu_muldiv;
    import alu_muldiv_pkg::*;

    localparam int W = 4;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int n_chk = 0;
    int n_fail = 0;
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] hilo_m = '0;

    alu_muldiv_if #(.DATA_W(W)) bus();
    alu_muldiv #(.DATA_W(W)) dut (.clock(clock), .reset_n(reset_n), .mdu(bus));

    always #5 clock = ~clock;

    function automatic logic [2*W-1:0] model(Alu_Func_T f, logic [W-1:0] a, logic [W-1:0] b,
                                             logic [2*W-1:0] hl);
        int sa, sb, ua, ub, p, q, r;
        logic [2*W-1:0] res;
        sa = int'($signed(a));
        sb = int'($signed(b));
        ua = int'(a);
        ub = int'(b);
        res = hl;
        case (f)
            ALU_MULT:  begin p = sa * sb; res = p[2*W-1:0]; end
            ALU_MULTU: begin p = ua * ub; res = p[2*W-1:0]; end
            ALU_DIV: begin
                if (b == '0) res = {a, {W{1'b1}}};
                else begin q = sa / sb; r = sa % sb; res = {r[W-1:0], q[W-1:0]}; end
            end
            ALU_DIVU: begin
                if (b == '0) res = {a, {W{1'b1}}};
                else begin q = ua / ub; r = ua % ub; res = {r[W-1:0], q[W-1:0]}; end
            end
`ifdef ALU_MULDIV_MADD_EN
            ALU_MADD:  begin p = sa * sb; res = hl + p[2*W-1:0]; end
            ALU_MADDU: begin p = ua * ub; res = hl + p[2*W-1:0]; end
            ALU_MSUB:  begin p = sa * sb; res = hl - p[2*W-1:0]; end
            ALU_MSUBU: begin p = ua * ub; res = hl - p[2*W-1:0]; end
`endif
            default: res = hl;
        endcase
        return res;
    endfunction

    task automatic read_hilo(output logic [W-1:0] hi, output logic [W-1:0] lo, output logic zlo);
        bus.issue = 1'b1;
        bus.func  = ALU_MFHI;
        #1 hi = bus.result;
        bus.func = ALU_MFLO;
        #1 lo = bus.result;
        zlo = bus.zero;
        bus.issue = 1'b0;
        bus.func  = ALU_ADD;
    endtask

    task automatic issue_op(Alu_Func_T f, logic [W-1:0] a, logic [W-1:0] b);
        hilo_m = model(f, a, b, hilo_m);
        exp_q.push_back(hilo_m);
        bus.issue = 1'b1;
        bus.func  = f;
        bus.data1 = a;
        bus.data2 = b;
        @(posedge clock);
        #1 bus.issue = 1'b0;
        bus.func = ALU_ADD;
    endtask

    task automatic set_hilo(logic [W-1:0] hi, logic [W-1:0] lo);
        bus.issue = 1'b1;
        bus.func  = ALU_MTHI;
        bus.data1 = hi;
        @(posedge clock);
        #1 bus.func = ALU_MTLO;
        bus.data1 = lo;
        @(posedge clock);
        #1 bus.issue = 1'b0;
        bus.func = ALU_ADD;
        hilo_m = {hi, lo};
    endtask

    task automatic wait_done(string name);
        int b = 0;
        bit got = 0;
        logic [W-1:0] hi, lo;
        logic zlo;
        logic [2*W-1:0] e;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            if (bus.done === 1'b1) got = 1;
            else if (bus.busy === 1'b1) b++;
        end
        n_chk++;
        if (!got) begin
            n_fail++;
            $display("FAIL %s_done: no done pulse within 20 cycles, expected one", name);
        end
        n_chk++;
        if (b != W + 1) begin
            n_fail++;
            $display("FAIL %s_busy_len: busy cycles %0d expected %0d", name, b, W + 1);
        end
        if (got) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL %s_scoreboard: done with empty queue, expected a pending op", name);
            end else begin
                e = exp_q.pop_front();
                read_hilo(hi, lo, zlo);
                if ({hi, lo} !== e) begin
                    n_fail++;
                    $display("FAIL %s_hilo: got HI=%h LO=%h expected HI=%h LO=%h", name, hi, lo, e[2*W-1:W], e[W-1:0]);
                end
                n_chk++;
                if (zlo !== (e[W-1:0] == '0)) begin
                    n_fail++;
                    $display("FAIL %s_zero: got %b expected %b", name, zlo, e[W-1:0] == '0);
                end
            end
        end
    endtask

    task automatic test_reset;
        logic [W-1:0] hi, lo;
        logic zlo;
        repeat (2) @(negedge clock);
        n_chk++;
        if ({bus.busy, bus.stall, bus.done, bus.zero} !== 4'b0001 || bus.result !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy/stall/done/zero=%b%b%b%b result=%h expected 0001 result=0",
                     bus.busy, bus.stall, bus.done, bus.zero, bus.result);
        end
        #1 reset_n = 1'b1;
        read_hilo(hi, lo, zlo);
        n_chk++;
        if ({hi, lo, zlo} !== {{2*W{1'b0}}, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_hilo: got HI=%h LO=%h zero=%b expected 0 0 1", hi, lo, zlo);
        end
    endtask

    task automatic test_move;
        logic [W-1:0] hi, lo;
        logic zlo;
        @(posedge clock);
        #1 set_hilo(4'h3, 4'hC);
        read_hilo(hi, lo, zlo);
        n_chk++;
        if ({hi, lo} !== 8'h3C || zlo !== 1'b0) begin
            n_fail++;
            $display("FAIL move_hilo: got HI=%h LO=%h zero=%b expected 3 C 0", hi, lo, zlo);
        end
        bus.issue = 1'b1;
        bus.func  = ALU_ADD;
        #1 n_chk++;
        if (bus.result !== '0 || bus.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL nonhilo_idle: result=%h stall=%b expected 0 0", bus.result, bus.stall);
        end
        bus.issue = 1'b0;
    endtask

    task automatic test_mult;
        issue_op(ALU_MULTU, 4'hA, 4'hA);
        wait_done("multu_a_a");
        issue_op(ALU_MULT, 4'hD, 4'h5);
        wait_done("mult_neg3_5");
        issue_op(ALU_MULT, 4'h8, 4'h8);
        wait_done("mult_min_min");
    endtask

    task automatic test_div;
        issue_op(ALU_DIV, 4'h7, 4'hE);
        wait_done("div_7_neg2");
        issue_op(ALU_DIV, 4'h8, 4'hF);
        wait_done("div_min_neg1");
        issue_op(ALU_DIVU, 4'h9, 4'h0);
        wait_done("divu_by_zero");
        issue_op(ALU_DIV, 4'hB, 4'h0);
        wait_done("div_neg_by_zero");
    endtask

    task automatic test_stall;
        logic [2*W-1:0] e;
        logic [W-1:0] hi, lo;
        logic zlo;
        int sc = 0;
        issue_op(ALU_MULTU, 4'h3, 4'h5);
        e = exp_q.pop_front();
        bus.issue = 1'b1;
        bus.func  = ALU_MFLO;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (bus.busy !== 1'b1) break;
            sc++;
            n_chk++;
            if (bus.stall !== 1'b1 || bus.result !== '0) begin
                n_fail++;
                $display("FAIL stall_mflo_busy: stall=%b result=%h expected stall=1 result=0", bus.stall, bus.result);
            end
        end
        n_chk++;
        if (sc != W + 1) begin
            n_fail++;
            $display("FAIL stall_mflo_len: stalled %0d cycles expected %0d", sc, W + 1);
        end
        n_chk++;
        if (bus.stall !== 1'b0 || bus.done !== 1'b1 || bus.result !== e[W-1:0]) begin
            n_fail++;
            $display("FAIL stall_mflo_release: stall=%b done=%b result=%h expected 0 1 %h",
                     bus.stall, bus.done, bus.result, e[W-1:0]);
        end
        @(posedge clock);
        #1 bus.issue = 1'b0;
        issue_op(ALU_MULTU, 4'h2, 4'h3);
        e = exp_q.pop_front();
        bus.issue = 1'b1;
        bus.func  = ALU_MTHI;
        bus.data1 = 4'h5;
        sc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (bus.busy !== 1'b1) break;
            sc++;
            n_chk++;
            if (bus.stall !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_mthi_busy: stall=%b expected 1", bus.stall);
            end
        end
        n_chk++;
        if (bus.stall !== 1'b0 || bus.done !== 1'b1 || sc != W + 1) begin
            n_fail++;
            $display("FAIL stall_mthi_release: stall=%b done=%b cycles=%0d expected 0 1 %0d", bus.stall, bus.done, sc, W + 1);
        end
        @(posedge clock);
        #1 bus.issue = 1'b0;
        bus.func = ALU_ADD;
        hilo_m = {4'h5, e[W-1:0]};
        read_hilo(hi, lo, zlo);
        n_chk++;
        if ({hi, lo} !== hilo_m) begin
            n_fail++;
            $display("FAIL stall_mthi_hilo: got HI=%h LO=%h expected HI=%h LO=%h", hi, lo, hilo_m[2*W-1:W], hilo_m[W-1:0]);
        end
    endtask

    task automatic test_back_to_back;
        Alu_Func_T ops[4] = '{ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU};
        for (int i = 0; i < 10; i++) begin
            issue_op(ops[$urandom_range(0, 3)], W'($urandom), W'($urandom));
            wait_done("b2b_random");
        end
    endtask

    task automatic test_reset_mid;
        logic [W-1:0] hi, lo;
        logic zlo;
        int dn = 0;
        set_hilo(4'h7, 4'h7);
        issue_op(ALU_MULTU, 4'hF, 4'hF);
        void'(exp_q.pop_back());
        repeat (2) @(negedge clock);
        bus.issue = 1'b1;
        bus.func  = ALU_ADD;
        #1 n_chk++;
        if (bus.busy !== 1'b1 || bus.stall !== 1'b0 || bus.result !== '0) begin
            n_fail++;
            $display("FAIL nonhilo_busy: busy=%b stall=%b result=%h expected 1 0 0", bus.busy, bus.stall, bus.result);
        end
        bus.issue = 1'b0;
        reset_n = 1'b0;
        hilo_m = '0;
        #1 n_chk++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_busy: busy=%b expected 0", bus.busy);
        end
        read_hilo(hi, lo, zlo);
        n_chk++;
        if ({hi, lo} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_hilo: got HI=%h LO=%h expected 0 0", hi, lo);
        end
        @(negedge clock);
        #1 reset_n = 1'b1;
        repeat (8) begin
            @(negedge clock);
            if (bus.done === 1'b1 || bus.busy === 1'b1) dn++;
        end
        n_chk++;
        if (dn != 0) begin
            n_fail++;
            $display("FAIL reset_mid_abort: busy/done seen %0d cycles after reset expected 0", dn);
        end
    endtask

`ifdef ALU_MULDIV_MADD_EN
    task automatic test_madd;
        @(posedge clock);
        #1 set_hilo(4'h0, 4'h1);
        issue_op(ALU_MADDU, 4'h3, 4'h3);
        wait_done("maddu_3_3");
        issue_op(ALU_MSUB, 4'hF, 4'h2);
        wait_done("msub_neg1_2");
        issue_op(ALU_MADD, 4'h8, 4'h8);
        wait_done("madd_min_min");
        issue_op(ALU_MSUBU, 4'hF, 4'hF);
        wait_done("msubu_f_f");
    endtask
`endif

    initial begin
        bus.issue = 1'b0;
        bus.func  = ALU_ADD;
        bus.data1 = '0;
        bus.data2 = '0;
        test_reset();
        test_move();
        test_mult();
        test_div();
        test_stall();
        test_back_to_back();
        test_reset_mid();
`ifdef ALU_MULDIV_MADD_EN
        test_madd();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, expected to have finished");
        $fatal(1, "watchdog");
    end
endmodule
